// File: rtl/sequential_divider_pkg.sv
// div_pkg: shared types and constants for the sequential divider
package div_pkg;
    localparam int XLEN = 32;
    localparam int CNT_W = 6;
    localparam logic [XLEN-1:0] DIV_ZERO_QUOT = '1;
    typedef enum logic [1:0] {IDLE, ITER, FIX} div_state_t;
endpackage

// File: rtl/sequential_divider_if.sv
// sequential_divider_if: start/busy/done handshake plus operands and results; abort exists under SEQ_DIV_ABORT_EN
interface sequential_divider_if #(parameter int N = div_pkg::XLEN) ();
    logic start;
    logic is_signed;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic busy;
    logic done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic div_by_zero;
`ifdef SEQ_DIV_ABORT_EN
    logic abort;
    modport master (output start, is_signed, dividend, divisor, abort,
                    input busy, done, quotient, remainder, div_by_zero);
    modport slave (input start, is_signed, dividend, divisor, abort,
                   output busy, done, quotient, remainder, div_by_zero);
`else
    modport master (output start, is_signed, dividend, divisor,
                    input busy, done, quotient, remainder, div_by_zero);
    modport slave (input start, is_signed, dividend, divisor,
                   output busy, done, quotient, remainder, div_by_zero);
`endif
endinterface

// File: rtl/sequential_divider_div_step.sv
// div_step: one restoring division step on magnitudes (shift, trial subtract, restore)
module div_step #(parameter int N = 32) (
    input  logic [N:0]   rem,
    input  logic [N-1:0] quo,
    input  logic [N-1:0] dsr,
    output logic [N:0]   rem_nxt,
    output logic [N-1:0] quo_nxt
);
    logic [N+1:0] sh;
    logic ge;
    assign sh = {rem, quo[N-1]};
    assign ge = sh >= {2'b0, dsr};
    assign rem_nxt = ge ? (N+1)'(sh - {2'b0, dsr}) : (N+1)'(sh);
    assign quo_nxt = {quo[N-2:0], ge};
endmodule

// File: rtl/sequential_divider.sv
// sequential_divider: 32-step restoring divider, signed/unsigned; abort input added when SEQ_DIV_ABORT_EN is defined
module sequential_divider
    import div_pkg::*;
#(parameter int N = XLEN) (
    input logic clk,
    input logic reset,
    sequential_divider_if.slave bus
);
    div_state_t state;
    logic [CNT_W-1:0] cnt;
    logic [N:0] rem, rem_nxt;
    logic [N-1:0] quo, quo_nxt, dsr;
    logic q_neg, r_neg, zero, a_neg, b_neg, abort_req;

    assign a_neg = bus.is_signed & bus.dividend[N-1];
    assign b_neg = bus.is_signed & bus.divisor[N-1];
`ifdef SEQ_DIV_ABORT_EN
    assign abort_req = bus.abort & (state != IDLE);
`else
    assign abort_req = 1'b0;
`endif

    div_step #(.N(N)) u_step (.rem(rem), .quo(quo), .dsr(dsr), .rem_nxt(rem_nxt), .quo_nxt(quo_nxt));

    // control FSM with datapath and registered outputs; a zero divisor skips ITER and carries the raw dividend in rem
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            rem <= '0;
            quo <= '0;
            dsr <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            zero <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.quotient <= '0;
            bus.remainder <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (abort_req) begin
                state <= IDLE;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        bus.busy <= 1'b1;
                        bus.div_by_zero <= 1'b0;
                        cnt <= '0;
                        zero <= bus.divisor == '0;
                        quo <= a_neg ? -bus.dividend : bus.dividend;
                        dsr <= b_neg ? -bus.divisor : bus.divisor;
                        q_neg <= a_neg ^ b_neg;
                        r_neg <= a_neg & (bus.divisor != '0);
                        rem <= (bus.divisor == '0) ? {1'b0, bus.dividend} : '0;
                        state <= (bus.divisor == '0) ? FIX : ITER;
                    end
                    ITER: begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(N-1)) state <= FIX;
                    end
                    FIX: begin
                        bus.quotient <= zero ? DIV_ZERO_QUOT : (q_neg ? -quo : quo);
                        bus.remainder <= r_neg ? -rem[N-1:0] : rem[N-1:0];
                        bus.div_by_zero <= zero;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sequential_divider.sv
// tb_sequential_divider: directed and random divisions checked against an arithmetic reference model
module tb_sequential_divider;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int passed = 0;
    int failed = 0;

    sequential_divider_if ifc ();
    sequential_divider dut (.clk(clk), .reset(reset), .bus(ifc));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa, sb, tq, tr;
        z = (b == 0);
        if (z) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            sa = s ? longint'($signed(a)) : longint'(a);
            sb = s ? longint'($signed(b)) : longint'(b);
            tq = sa / sb;
            tr = sa % sb;
            q = tq[31:0];
            r = tr[31:0];
        end
    endfunction

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input int pulse_at, input string tag);
        logic [31:0] q, r;
        logic z, stay, seen;
        int n;
        model(a, b, s, q, r, z);
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.is_signed = s;
        ifc.dividend = a;
        ifc.divisor = b;
        tick();
        ifc.start = 1'b0;
        ifc.is_signed = ~s;
        ifc.dividend = $urandom;
        ifc.divisor = $urandom;
        chk({tag, ".busy_accept"}, 32'(ifc.busy), 32'd1);
        chk({tag, ".dbz_clear"}, 32'(ifc.div_by_zero), 32'd0);
        n = 0;
        stay = 1'b1;
        while (!ifc.done && n < 60) begin
            ifc.start = (n == pulse_at - 1);
            stay &= ifc.busy;
            tick();
            n++;
        end
        ifc.start = 1'b0;
        chk({tag, ".latency"}, 32'(n), z ? 32'd1 : 32'd33);
        chk({tag, ".busy_held"}, 32'(stay), 32'd1);
        chk({tag, ".busy_done"}, 32'(ifc.busy), 32'd0);
        chk({tag, ".quot"}, ifc.quotient, q);
        chk({tag, ".rem"}, ifc.remainder, r);
        chk({tag, ".dbz"}, 32'(ifc.div_by_zero), 32'(z));
        seen = 1'b0;
        repeat (3) begin
            tick();
            seen |= ifc.done | ifc.busy;
        end
        chk({tag, ".single_done"}, 32'(seen), 32'd0);
        chk({tag, ".quot_held"}, ifc.quotient, q);
    endtask

    initial begin
        logic seen;
        logic [31:0] a, b;
        ifc.start = 1'b0;
        ifc.is_signed = 1'b0;
        ifc.dividend = '0;
        ifc.divisor = '0;
`ifdef SEQ_DIV_ABORT_EN
        ifc.abort = 1'b0;
`endif
        repeat (3) tick();
        chk("rst.busy", 32'(ifc.busy), 32'd0);
        chk("rst.done", 32'(ifc.done), 32'd0);
        chk("rst.quot", ifc.quotient, 32'd0);
        chk("rst.rem", ifc.remainder, 32'd0);
        chk("rst.dbz", 32'(ifc.div_by_zero), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run(32'd100, 32'd7, 1'b1, 0, "s100_7");
        run(-32'd100, 32'd7, 1'b1, 0, "sm100_7");
        run(32'd100, -32'd7, 1'b1, 0, "s100_m7");
        run(32'd5, 32'd0, 1'b1, 0, "s5_0");
        run(32'd5, 32'd0, 1'b0, 0, "u5_0");
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "ovf");
        run(32'hFFFF_FFFF, 32'd2, 1'b0, 0, "uFF_2");
        run(32'h1234, 32'd3, 1'b0, 5, "restart");

        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = ($urandom_range(3) == 0) ? 32'($urandom_range(15)) : $urandom;
            run(a, b, 1'($urandom_range(1)), 0, "rand");
        end

        @(negedge clk);
        ifc.start = 1'b1;
        ifc.is_signed = 1'b0;
        ifc.dividend = 32'h1234;
        ifc.divisor = 32'd3;
        tick();
        ifc.start = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        #1;
        chk("arst.busy", 32'(ifc.busy), 32'd0);
        chk("arst.done", 32'(ifc.done), 32'd0);
        chk("arst.quot", ifc.quotient, 32'd0);
        chk("arst.rem", ifc.remainder, 32'd0);
        chk("arst.dbz", 32'(ifc.div_by_zero), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            tick();
            seen |= ifc.done | ifc.busy;
        end
        chk("arst.no_done", 32'(seen), 32'd0);

`ifdef SEQ_DIV_ABORT_EN
        run(32'd100, 32'd7, 1'b1, 0, "pre_abort");
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.is_signed = 1'b0;
        ifc.dividend = 32'h1234;
        ifc.divisor = 32'd3;
        tick();
        ifc.start = 1'b0;
        repeat (12) tick();
        ifc.abort = 1'b1;
        tick();
        ifc.abort = 1'b0;
        chk("abort.busy", 32'(ifc.busy), 32'd0);
        chk("abort.quot", ifc.quotient, 32'd14);
        chk("abort.rem", ifc.remainder, 32'd2);
        seen = 1'b0;
        repeat (40) begin
            tick();
            seen |= ifc.done | ifc.busy;
        end
        chk("abort.no_done", 32'(seen), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
